// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared register-file constants and writeback entry type
package rv_pkg;

   localparam int XLEN       = 64;
   localparam int REG_ADDR_W = 5;
   localparam int NREGS      = 32;

   localparam int SRC_ALU  = 0;
   localparam int SRC_MUL  = 1;
   localparam int SRC_LOAD = 2;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - small in-order writeback buffer for one source
module wb_fifo
   import rv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_push,
   input  logic      i_pop,
   input  wb_entry_t i_din,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t      r_mem [DEPTH];
   logic [AW-1:0]  r_wptr;
   logic [AW-1:0]  r_rptr;
   logic [AW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_head    = r_mem[r_rptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_do_pop)
            r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin serialiser of writeback results onto the register-file write port
// Optional pending-write scoreboard output (busy) enabled by WB_SCOREBOARD_EN.
module wb_arbiter #(
   parameter int XLEN  = rv_pkg::XLEN,
   parameter int NSRC  = 3,
   parameter int DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NSRC-1:0]    src_valid,
   output logic [NSRC-1:0]    src_ready,
   input  logic [NSRC*5-1:0]  src_addr,
   input  logic [NSRC*XLEN-1:0] src_data,
   output logic               wr_en,
   output logic [4:0]         wr_addr,
   output logic [XLEN-1:0]    wr_data
`ifdef WB_SCOREBOARD_EN
   ,
   output logic [31:0]        busy
`endif
);

   localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

   rv_pkg::wb_entry_t w_src_entry [NSRC];
   rv_pkg::wb_entry_t w_head      [NSRC];
   rv_pkg::wb_entry_t w_gnt_entry;
   logic [NSRC-1:0]   w_full;
   logic [NSRC-1:0]   w_empty;
   logic [NSRC-1:0]   w_push;
   logic [NSRC-1:0]   w_pop;
   logic              w_gnt_vld;
   logic [SW-1:0]     w_gnt_idx;
   logic [SW-1:0]     r_last;

   for (genvar g = 0; g < NSRC; g++) begin : g_src
      assign w_src_entry[g].addr = src_addr[5*g +: 5];
      assign w_src_entry[g].data = src_data[XLEN*g +: XLEN];
      assign src_ready[g]        = !rst && !w_full[g];
      // x0 results are consumed by the handshake but never enter the buffer
      assign w_push[g] = src_valid[g] && src_ready[g] && (w_src_entry[g].addr != '0);

      wb_fifo #(.DEPTH(DEPTH)) u_fifo (
         .i_clk   (clk),
         .i_rst   (rst),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_din   (w_src_entry[g]),
         .o_head  (w_head[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   always_comb begin
      int idx;
      w_gnt_vld = 1'b0;
      w_gnt_idx = '0;
      idx       = 0;
      for (int k = 1; k <= NSRC; k++) begin
         idx = (int'(r_last) + k) % NSRC;
         if (!w_gnt_vld && !w_empty[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SW'(idx);
         end
      end
   end

   always_comb begin
      w_pop = '0;
      for (int i = 0; i < NSRC; i++)
         w_pop[i] = w_gnt_vld && (w_gnt_idx == SW'(i));
   end

   assign w_gnt_entry = w_head[w_gnt_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         r_last  <= SW'(NSRC - 1);
      end else begin
         wr_en <= w_gnt_vld;
         if (w_gnt_vld) begin
            wr_addr <= w_gnt_entry.addr;
            wr_data <= w_gnt_entry.data;
            r_last  <= w_gnt_idx;
         end
      end
   end

`ifdef WB_SCOREBOARD_EN
   localparam int CW = $clog2(NSRC*DEPTH + 1);

   logic [CW-1:0]            r_pend     [rv_pkg::NREGS];
   logic [CW-1:0]            w_pend_nxt [rv_pkg::NREGS];
   logic [rv_pkg::NREGS-1:0] r_busy;

   // Several sources may target the same register in one cycle, so count every push
   always_comb begin
      for (int r = 0; r < rv_pkg::NREGS; r++) begin
         w_pend_nxt[r] = r_pend[r];
         for (int i = 0; i < NSRC; i++)
            if (w_push[i] && (w_src_entry[i].addr == 5'(r)))
               w_pend_nxt[r] = w_pend_nxt[r] + CW'(1);
         if (w_gnt_vld && (w_gnt_entry.addr == 5'(r)))
            w_pend_nxt[r] = w_pend_nxt[r] - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
         for (int r = 0; r < rv_pkg::NREGS; r++)
            r_pend[r] <= '0;
      end else begin
         for (int r = 0; r < rv_pkg::NREGS; r++) begin
            r_pend[r] <= w_pend_nxt[r];
            r_busy[r] <= (r != 0) && (w_pend_nxt[r] != '0);
         end
      end
   end

   assign busy = r_busy;
`endif

endmodule
